// File: rtl/writeback_unit.sv
// Writeback stage with integrated register file and retirement counter.
// The Memory-stage result is selected, captured into the Writeback stage,
// written to the register file, and counted as retired.
//
// Optional feature: define WB_BYPASS_EN to forward the Writeback-stage value
// onto op1/op2 when it targets the register being read.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   validM, isWb, isLd, isCall Memory-stage valid and control bits
//   rd                         destination register
//   aluResult, ldResult, pcM   candidate results and Memory-stage PC
//   stall, flush               hold / kill Writeback capture
//   rs1, rs2 -> op1, op2       combinational register reads
//   wbValid, wbRd, wbData      Writeback-stage contents (registered)
//   retired                    retired-instruction count (registered)
module writeback_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_COUNT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validM,
  input  logic              isWb,
  input  logic              isLd,
  input  logic              isCall,
  input  logic [3:0]        rd,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] ldResult,
  input  logic [DATA_W-1:0] pcM,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic              wbValid,
  output logic [3:0]        wbRd,
  output logic [DATA_W-1:0] wbData,
  output logic [31:0]       retired
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 32;

  logic [DATA_W-1:0] regfile [REG_COUNT];
  logic [DATA_W-1:0] result_c;

  // Result select: call return address beats load data beats ALU result.
  always_comb begin
    result_c = aluResult;
    if (isCall) begin
      result_c = pcM + DATA_W'(4);
    end else if (isLd) begin
      result_c = ldResult;
    end
  end

  // Writeback stage register; flush kills only the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbValid <= 1'b0;
      wbRd    <= '0;
      wbData  <= '0;
    end else if (flush) begin
      wbValid <= 1'b0;
    end else if (!stall) begin
      wbValid <= validM & isWb;
      wbRd    <= rd;
      wbData  <= result_c;
    end
  end

  // An instruction retires when it leaves the stage (advanced or flushed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (wbValid && (!stall || flush)) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Register file write; repeated writes while stalled are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regfile[IDX_W'(i)] <= '0;
      end
    end else if (wbValid) begin
      regfile[wbRd] <= wbData;
    end
  end

  // Register reads, optionally forwarding the in-flight Writeback value.
  always_comb begin
`ifdef WB_BYPASS_EN
    op1 = (wbValid && (wbRd == rs1)) ? wbData : regfile[rs1];
    op2 = (wbValid && (wbRd == rs2)) ? wbData : regfile[rs2];
`else
    op1 = regfile[rs1];
    op2 = regfile[rs2];
`endif
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: scoreboard of captured Writeback
// contents plus a small model of the register file and retirement count.
`timescale 1ns/100ps
module tb_writeback_unit;

  typedef struct packed {
    logic        v;
    logic [3:0]  rd;
    logic [31:0] d;
  } wb_t;

  logic        clk, rst_n;
  logic        validM, isWb, isLd, isCall, stall, flush;
  logic [3:0]  rd, rs1, rs2, wbRd;
  logic [31:0] aluResult, ldResult, pcM, op1, op2, wbData, retired;
  logic        wbValid;

  int checks = 0;
  int errors = 0;

  wb_t         exp_q[$];
  logic [31:0] mrf [16];
  logic        m_valid;
  logic [3:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] exp_retired;

  writeback_unit #(.DATA_W(32), .REG_COUNT(16)) dut (
    .clk(clk), .rst_n(rst_n), .validM(validM), .isWb(isWb), .isLd(isLd),
    .isCall(isCall), .rd(rd), .aluResult(aluResult), .ldResult(ldResult),
    .pcM(pcM), .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
    .op1(op1), .op2(op2), .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] res_model();
    if (isCall) return pcM + 32'd4;
    if (isLd) return ldResult;
    return aluResult;
  endfunction

  function automatic logic [31:0] exp_op(input logic [3:0] r);
`ifdef WB_BYPASS_EN
    if (m_valid && m_rd == r) return m_data;
`endif
    return mrf[r];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    m_valid = 1'b0; m_rd = '0; m_data = '0; exp_retired = '0;
    exp_q.delete();
  endfunction

  task automatic drive(input logic v, input logic w, input logic l, input logic c,
                       input logic [3:0] r, input logic [31:0] a,
                       input logic [31:0] ld, input logic [31:0] pc);
    validM = v; isWb = w; isLd = l; isCall = c; rd = r;
    aluResult = a; ldResult = ld; pcM = pc;
  endtask

  // Advance one clock edge, updating the model and scoreboard for that edge.
  task automatic step();
    if (m_valid && (!stall || flush)) exp_retired = exp_retired + 32'd1;
    if (m_valid) mrf[m_rd] = m_data;
    if (flush) begin
      m_valid = 1'b0;
    end else if (!stall) begin
      m_valid = validM & isWb; m_rd = rd; m_data = res_model();
      exp_q.push_back('{v: validM & isWb, rd: rd, d: res_model()});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if (wbValid !== 1'b0 || wbRd !== 4'd0 || wbData !== 32'd0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b rd=%0d d=%h ret=%h want all zero",
               wbValid, wbRd, wbData, retired);
    end
    for (int i = 0; i < 16; i++) begin
      rs1 = 4'(i); rs2 = 4'(15 - i); #1;
      checks++;
      if (op1 !== 32'd0 || op2 !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg%0d: got op1=%h op2=%h want 0", i, op1, op2);
      end
    end
  endtask

  task automatic test_basic();
    wb_t e;
    drive(1, 1, 0, 0, 4'd3, 32'h1234, 32'h0, 32'h0);
    rs1 = 4'd3;
    step();
    e = exp_q.pop_front();
    checks++;
    if (wbValid !== 1'b1 || wbRd !== 4'd3 || wbData !== 32'h1234 || e.d !== 32'h1234) begin
      errors++;
      $display("FAIL basic_capture: got v=%b rd=%0d d=%h want v=1 rd=3 d=1234",
               wbValid, wbRd, wbData);
    end
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    #1;
    checks++;
`ifdef WB_BYPASS_EN
    if (op1 !== 32'h1234) begin
`else
    if (op1 !== 32'h0) begin
`endif
      errors++;
      $display("FAIL basic_same_cycle_read: got op1=%h want %h", op1, exp_op(4'd3));
    end
    step();
    e = exp_q.pop_front();
    checks++;
    if (op1 !== 32'h1234 || wbValid !== e.v || retired !== exp_retired) begin
      errors++;
      $display("FAIL basic_after_write: got op1=%h v=%b ret=%h want op1=1234 v=%b ret=%h",
               op1, wbValid, retired, e.v, exp_retired);
    end
  endtask

  task automatic test_select();
    logic        vs [6] = '{1, 1, 1, 1, 0, 0};
    logic        ws [6] = '{1, 1, 1, 0, 1, 0};
    logic        ls [6] = '{0, 1, 1, 0, 0, 0};
    logic        cs [6] = '{0, 1, 0, 0, 1, 0};
    logic [3:0]  rs [6] = '{15, 15, 7, 8, 9, 0};
    logic [31:0] as [6] = '{32'hDEADBEEF, 32'h11, 32'h22, 32'h99, 32'h33, 32'h0};
    logic [31:0] ds [6] = '{32'h0, 32'h44, 32'h55AA, 32'h66, 32'h77, 32'h0};
    logic [31:0] ps [6] = '{32'h0, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h100, 32'h0};
    logic [31:0] want [6] = '{32'hDEADBEEF, 32'h0, 32'h55AA, 32'h99, 32'h104, 32'h0};
    wb_t e;
    for (int i = 0; i < 6; i++) begin
      drive(vs[i], ws[i], ls[i], cs[i], rs[i], as[i], ds[i], ps[i]);
      step();
      e = exp_q.pop_front();
      checks++;
      if (wbValid !== e.v || wbRd !== e.rd || wbData !== e.d || wbData !== want[i]) begin
        errors++;
        $display("FAIL select_%0d: got v=%b rd=%0d d=%h want v=%b rd=%0d d=%h",
                 i, wbValid, wbRd, wbData, e.v, e.rd, want[i]);
      end
    end
    step();
    void'(exp_q.pop_front());
    rs1 = 4'd7; rs2 = 4'd15; #1;
    checks++;
    if (op1 !== 32'h55AA || op2 !== 32'h0) begin
      errors++;
      $display("FAIL select_regs: got r7=%h r15=%h want r7=55aa r15=0", op1, op2);
    end
    rs1 = 4'd8; rs2 = 4'd9; #1;
    checks++;
    if (op1 !== 32'h0 || op2 !== 32'h0) begin
      errors++;
      $display("FAIL select_ignored: got r8=%h r9=%h want 0 0", op1, op2);
    end
    rs1 = 4'd7; rs2 = 4'd7; #1;
    checks++;
    if (op1 !== 32'h55AA || op2 !== 32'h55AA) begin
      errors++;
      $display("FAIL same_addr: got op1=%h op2=%h want 55aa 55aa", op1, op2);
    end
    checks++;
    if (retired !== exp_retired) begin
      errors++;
      $display("FAIL select_retired: got %h want %h", retired, exp_retired);
    end
  endtask

  task automatic test_stall();
    wb_t e;
    logic [31:0] r0;
    drive(1, 1, 0, 0, 4'd4, 32'h44, 32'h0, 32'h0);
    step();
    e = exp_q.pop_front();
    r0 = exp_retired;
    stall = 1'b1;
    drive(1, 1, 0, 0, 4'd6, 32'h66, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (wbValid !== 1'b1 || wbRd !== 4'd4 || wbData !== 32'h44 || retired !== r0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b rd=%0d d=%h ret=%h want v=1 rd=4 d=44 ret=%h",
                 i, wbValid, wbRd, wbData, retired, r0);
      end
    end
    stall = 1'b0;
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    step();
    e = exp_q.pop_front();
    rs1 = 4'd4; rs2 = 4'd6; #1;
    checks++;
    if (retired !== r0 + 32'd1 || wbValid !== e.v || op1 !== 32'h44 || op2 !== 32'h0) begin
      errors++;
      $display("FAIL stall_release: got ret=%h v=%b r4=%h r6=%h want ret=%h v=0 r4=44 r6=0",
               retired, wbValid, op1, op2, r0 + 32'd1);
    end
  endtask

  task automatic test_flush();
    wb_t e;
    logic [31:0] r0;
    drive(1, 1, 0, 0, 4'd5, 32'hAA, 32'h0, 32'h0);
    step();
    e = exp_q.pop_front();
    r0 = exp_retired;
    drive(1, 1, 0, 0, 4'd10, 32'hBB, 32'h0, 32'h0);
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    rs1 = 4'd5; rs2 = 4'd10; #1;
    checks++;
    if (wbValid !== 1'b0 || wbRd !== 4'd5 || wbData !== 32'hAA ||
        retired !== r0 + 32'd1 || op1 !== 32'hAA || op2 !== 32'h0) begin
      errors++;
      $display("FAIL flush_stall: got v=%b rd=%0d d=%h ret=%h r5=%h r10=%h want v=0 rd=5 d=aa ret=%h r5=aa r10=0",
               wbValid, wbRd, wbData, retired, op1, op2, r0 + 32'd1);
    end
  endtask

  task automatic test_wrap();
    wb_t e;
    drive(1, 1, 0, 0, 4'd1, 32'h1, 32'h0, 32'h0);
    step();
    e = exp_q.pop_front();
    stall = 1'b1;
    force dut.retired = 32'hFFFFFFFF;
    step();
    checks++;
    if (retired !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h want ffffffff", retired);
    end
    release dut.retired;
    exp_retired = 32'hFFFFFFFF;
    stall = 1'b0;
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    step();
    e = exp_q.pop_front();
    checks++;
    if (retired !== 32'h0 || exp_retired !== 32'h0) begin
      errors++;
      $display("FAIL wrap: got %h want 0", retired);
    end
  endtask

  task automatic test_reset_mid();
    wb_t e;
    logic bad;
    drive(1, 1, 0, 0, 4'd2, 32'h22, 32'h0, 32'h0);
    step();
    e = exp_q.pop_front();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (wbValid !== 1'b0 || wbRd !== 4'd0 || wbData !== 32'd0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got v=%b rd=%0d d=%h ret=%h want all zero",
               wbValid, wbRd, wbData, retired);
    end
    bad = 1'b0;
    for (int i = 0; i < 16; i++) if (dut.regfile[i] !== 32'd0) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_regs: got r1=%h r4=%h r5=%h r7=%h want all 0",
               dut.regfile[1], dut.regfile[4], dut.regfile[5], dut.regfile[7]);
    end
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 1, 0, 0, 4'd2, 32'h77, 32'h0, 32'h0);
    step();
    e = exp_q.pop_front();
    checks++;
    if (wbValid !== e.v || wbRd !== e.rd || wbData !== e.d) begin
      errors++;
      $display("FAIL reset_resume: got v=%b rd=%0d d=%h want v=%b rd=%0d d=%h",
               wbValid, wbRd, wbData, e.v, e.rd, e.d);
    end
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    step();
    void'(exp_q.pop_front());
    rs1 = 4'd2; #1;
    checks++;
    if (op1 !== 32'h77 || retired !== exp_retired) begin
      errors++;
      $display("FAIL reset_resume_write: got r2=%h ret=%h want r2=77 ret=%h",
               op1, retired, exp_retired);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; rs1 = '0; rs2 = '0;
    drive(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_select();
    test_stall();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
